// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin front end that feeds one shared 16x16 signed
// radix-4 Booth multiplier through a two-stage pipeline (operand register,
// product register). Results come back on one tagged valid/ready channel.
module booth_mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_REQ-1:0]     i_req_valid,
  output logic [N_REQ-1:0]     o_req_ready,
  input  logic [16*N_REQ-1:0]  i_req_x,
  input  logic [16*N_REQ-1:0]  i_req_y,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready,
  output logic [ID_W-1:0]      o_resp_id,
  output logic [31:0]          o_resp_product,
  output logic [15:0]          o_op_count
);
  // width of a requester index as used for selects
  localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ID_W-1:0] r_rr_ptr;
  logic            r_s1_valid, r_s2_valid;
  logic [15:0]     r_s1_x, r_s1_y;
  logic [ID_W-1:0] r_s1_id, r_s2_id;
  logic [31:0]     r_s2_prod;
  logic [15:0]     r_op_count;

  logic            w_s2_adv, w_s1_adv, w_found, w_hs;
  logic [SW-1:0]   w_gsel;
  logic [ID_W-1:0] w_gidx;
  logic [15:0]     w_x [N_REQ];
  logic [15:0]     w_y [N_REQ];

  // unpack the flat operand buses into per-requester lanes
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign w_x[i] = i_req_x[16*i +: 16];
    assign w_y[i] = i_req_y[16*i +: 16];
  end

  // a stage may take new data when it is empty or its contents move on
  assign w_s2_adv = !r_s2_valid || i_resp_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  // first valid requester at or after the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_gsel  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_found && i_req_valid[SW'(idx)]) begin
        w_found = 1'b1;
        w_gsel  = SW'(idx);
      end
    end
  end

  assign w_gidx = ID_W'(w_gsel);
  assign w_hs   = i_rst_n && w_s1_adv && w_found;

  // one-hot accept, suppressed while reset is held
  always_comb begin
    o_req_ready = '0;
    if (w_hs) o_req_ready[w_gsel] = 1'b1;
  end

  // radix-4 Booth recoding: eight signed partial products of x, each picking
  // 0, +-x or +-2x from an overlapping 3-bit window of y
  logic [31:0] w_xe;
  logic [16:0] w_yext;
  logic [31:0] w_pp [8];
  logic [31:0] w_acc;

  assign w_xe   = {{16{r_s1_x[15]}}, r_s1_x};
  assign w_yext = {r_s1_y, 1'b0};

  for (genvar j = 0; j < 8; j++) begin : g_pp
    logic [2:0]  w_trip;
    logic [31:0] w_sel;
    assign w_trip = w_yext[2*j+2 -: 3];
    // map the Booth digit to a multiple of x
    always_comb begin
      w_sel = '0;
      case (w_trip)
        3'b001, 3'b010: w_sel = w_xe;
        3'b011:         w_sel = w_xe << 1;
        3'b100:         w_sel = -(w_xe << 1);
        3'b101, 3'b110: w_sel = -w_xe;
        default:        w_sel = '0;
      endcase
    end
    assign w_pp[j] = w_sel << (2*j);
  end

  // reduce partial products; modulo-2^32 sum gives the exact signed product
  always_comb begin
    w_acc = '0;
    for (int j = 0; j < 8; j++) w_acc = w_acc + w_pp[j];
  end

  // arbitration pointer and operand stage
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_id    <= '0;
    end else begin
      if (w_hs)
        r_rr_ptr <= (int'(w_gsel) == N_REQ-1) ? '0 : w_gidx + 1'b1;
      if (w_s1_adv) begin
        r_s1_valid <= w_found;
        if (w_found) begin
          r_s1_x  <= w_x[w_gsel];
          r_s1_y  <= w_y[w_gsel];
          r_s1_id <= w_gidx;
        end
      end
    end
  end

  // product stage; holds steady while the consumer stalls
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_prod  <= '0;
      r_s2_id    <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_prod <= w_acc;
        r_s2_id   <= r_s1_id;
      end
    end
  end

  // completed-response counter, wraps naturally at 16 bits
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                       r_op_count <= '0;
    else if (r_s2_valid && i_resp_ready) r_op_count <= r_op_count + 16'd1;
  end

  assign o_resp_valid   = r_s2_valid;
  assign o_resp_id      = r_s2_id;
  assign o_resp_product = r_s2_prod;
  assign o_op_count     = r_op_count;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: a transaction-level model (capacity-2 FIFO
// with ages, rotating-priority grant, product via native multiply) checked
// every cycle, plus directed scenarios with literal expectations.
module tb_booth_mult_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready;
  logic [16*N-1:0] req_x, req_y;
  logic            resp_valid, resp_ready;
  logic [IW-1:0]   resp_id;
  logic [31:0]     resp_product;
  logic [15:0]     op_count;

  always #5 clk = ~clk;

  booth_mult_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_x(req_x), .i_req_y(req_y), .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_id(resp_id), .o_resp_product(resp_product), .o_op_count(op_count));

  int total = 0, bad = 0;

  typedef struct { int id; logic [31:0] p; int age; } ent_t;
  typedef struct { int id; logic [31:0] p; int cyc; } obs_t;
  ent_t q[$];
  obs_t acc_log[$], rsp_log[$];

  int          m_ptr = 0;
  logic [15:0] m_cnt = '0;
  bit          armed = 0;
  int          acc_id = -1;
  logic [31:0] acc_p;
  bit          rsp_hs = 0;
  int          cyc = 0, n_rsp = 0;
  bit          log_en = 1;
  logic        pv = 0, pr = 0;
  logic [IW-1:0] pid;
  logic [31:0] pp;
  bit          prst = 0;

  int          rem [N];
  logic [15:0] opx [N], opy [N];
  logic [N-1:0] hs_q = '0;

  int eg, ix;
  logic [N-1:0] er;
  bit ev;
  logic signed [15:0] xs, ys;
  ent_t ne;
  obs_t no;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = rem[i] > 0;
      req_x[16*i +: 16]  = opx[i];
      req_y[16*i +: 16]  = opy[i];
    end
  endtask

  // advance one cycle; requesters replace operands after each accept
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs_q[i]) begin
        rem[i] = rem[i] - 1;
        opx[i] = 16'($urandom);
        opy[i] = 16'($urandom);
      end
    drive();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // model state update at the clock edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      q.delete();
      m_ptr = 0;
      m_cnt = '0;
      armed = 1;
    end else if (armed) begin
      foreach (q[i]) q[i].age++;
      if (rsp_hs) begin
        void'(q.pop_front());
        m_cnt++;
      end
      if (acc_id >= 0) begin
        ne.id = acc_id; ne.p = acc_p; ne.age = 0;
        q.push_back(ne);
        m_ptr = (acc_id + 1) % N;
      end
    end
  end

  // compare DUT against the model mid-cycle
  always @(negedge clk) begin
    hs_q = req_valid & req_ready;
    if (!rst_n) begin
      chk("ready_in_reset", 32'(req_ready), 0);
      acc_id = -1;
      rsp_hs = 0;
    end else if (armed) begin
      eg = -1;
      if (q.size() < 2 || resp_ready)
        for (int k = 0; k < N; k++) begin
          ix = (m_ptr + k) % N;
          if (eg < 0 && req_valid[ix]) eg = ix;
        end
      er = '0;
      if (eg >= 0) er[eg] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      ev = q.size() > 0 && q[0].age >= 1;
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      if (ev) begin
        chk("resp_id", 32'(resp_id), q[0].id);
        chk("resp_product", resp_product, q[0].p);
      end
      chk("op_count", 32'(op_count), 32'(m_cnt));
      if (prst && pv && !pr) begin
        chk("stall_valid", 32'(resp_valid), 1);
        chk("stall_id", 32'(resp_id), 32'(pid));
        chk("stall_product", resp_product, pp);
      end
      acc_id = eg;
      if (eg >= 0) begin
        xs = req_x[16*eg +: 16];
        ys = req_y[16*eg +: 16];
        acc_p = xs * ys;
      end
      rsp_hs = ev && resp_ready;
      for (int i = 0; i < N; i++)
        if (log_en && req_valid[i] && req_ready[i]) begin
          no.id = i; no.p = '0; no.cyc = cyc;
          acc_log.push_back(no);
        end
      if (resp_valid && resp_ready) begin
        n_rsp++;
        if (log_en) begin
          no.id = int'(resp_id); no.p = resp_product; no.cyc = cyc;
          rsp_log.push_back(no);
        end
      end
    end
    pv = resp_valid; pr = resp_ready; pid = resp_id; pp = resp_product;
    prst = rst_n && armed;
  end

  logic [15:0] ex [3] = '{16'h8000, 16'h7FFF, 16'h0000};
  logic [15:0] ey [3] = '{16'h8000, 16'h8000, 16'h1234};
  logic [31:0] ep [3] = '{32'h4000_0000, 32'hC000_8000, 32'h0000_0000};

  initial begin
    int s, c1, c2, guard;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin rem[i] = 0; opx[i] = '0; opy[i] = '0; end
    drive();
    tick();
    apply_reset();
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_resp_product", resp_product, 0);
    chk("rst_op_count", 32'(op_count), 0);

    // single request from requester 2
    acc_log.delete(); rsp_log.delete();
    opx[2] = 16'h0003; opy[2] = 16'hFFFB; rem[2] = 1; drive();
    repeat (6) tick();
    chk("single_acc_n", acc_log.size(), 1);
    chk("single_rsp_n", rsp_log.size(), 1);
    if (acc_log.size() > 0 && rsp_log.size() > 0) begin
      chk("single_acc_id", acc_log[0].id, 2);
      chk("single_rsp_id", rsp_log[0].id, 2);
      chk("single_product", rsp_log[0].p, 32'hFFFF_FFF1);
      chk("single_latency", rsp_log[0].cyc - acc_log[0].cyc, 2);
    end
    chk("single_count", 32'(op_count), 1);

    // operand extremes through requester 1
    acc_log.delete(); rsp_log.delete();
    for (int v = 0; v < 3; v++) begin
      opx[1] = ex[v]; opy[1] = ey[v]; rem[1] = 1; drive();
      repeat (4) tick();
    end
    chk("ext_rsp_n", rsp_log.size(), 3);
    for (int v = 0; v < 3; v++)
      if (v < rsp_log.size()) chk("ext_product", rsp_log[v].p, ep[v]);

    // fairness with all requesters busy
    apply_reset();
    acc_log.delete(); rsp_log.delete();
    for (int i = 0; i < N; i++) begin rem[i] = 3; opx[i] = 16'($urandom); opy[i] = 16'($urandom); end
    drive();
    repeat (18) tick();
    chk("rr_acc_n", acc_log.size(), 12);
    chk("rr_rsp_n", rsp_log.size(), 12);
    for (int k = 0; k < 12; k++)
      if (k < acc_log.size() && k < rsp_log.size()) begin
        chk("rr_grant_id", acc_log[k].id, k % 4);
        chk("rr_grant_cyc", acc_log[k].cyc, acc_log[0].cyc + k);
        chk("rr_rsp_id", rsp_log[k].id, k % 4);
        chk("rr_rsp_cyc", rsp_log[k].cyc, rsp_log[0].cyc + k);
      end

    // backpressure: only two ops fit, then release
    acc_log.delete(); rsp_log.delete();
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) rem[i] = 2;
    drive();
    repeat (5) tick();
    chk("bp_acc_held", acc_log.size(), 2);
    chk("bp_rsp_held", rsp_log.size(), 0);
    chk("bp_ready_zero", 32'(req_ready), 0);
    resp_ready = 1'b1;
    repeat (16) tick();
    chk("bp_acc_n", acc_log.size(), 8);
    chk("bp_rsp_n", rsp_log.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < acc_log.size() && k < rsp_log.size())
        chk("bp_order", rsp_log[k].id, acc_log[k].id);

    // reset with both stages full
    apply_reset();
    acc_log.delete(); rsp_log.delete();
    resp_ready = 1'b0;
    rem[1] = 2; rem[2] = 1; rem[3] = 3; drive();
    repeat (3) tick();
    chk("mid_acc_n", acc_log.size(), 2);
    chk("mid_full_valid", 32'(resp_valid), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_resp_valid", 32'(resp_valid), 0);
    chk("mid_op_count", 32'(op_count), 0);
    chk("mid_resp_product", resp_product, 0);
    s = acc_log.size();
    resp_ready = 1'b1;
    repeat (12) tick();
    if (s < acc_log.size()) chk("mid_first_grant", acc_log[s].id, 1);
    chk("mid_rsp_n", rsp_log.size(), 4);
    c1 = 0; c2 = 0;
    foreach (rsp_log[k]) begin
      if (rsp_log[k].id == 1) c1++;
      if (rsp_log[k].id == 2) c2++;
    end
    chk("mid_id1_count", c1, 1);
    chk("mid_id2_count", c2, 0);

    // counter wrap after 65536 completions
    apply_reset();
    log_en = 0;
    n_rsp = 0;
    for (int i = 0; i < N; i++) rem[i] = 16384;
    drive();
    guard = 0;
    while (n_rsp < 65535 && guard < 70000) begin tick(); guard++; end
    chk("wrap_reached", 32'(n_rsp), 65535);
    chk("wrap_ffff", 32'(op_count), 32'h0000_FFFF);
    guard = 0;
    while (n_rsp < 65536 && guard < 10) begin tick(); guard++; end
    chk("wrap_zero", 32'(op_count), 0);
    repeat (4) tick();
    chk("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
